fsic_axis_rx_fifo: RTL and testbench
====================================

# fsic_axis_rx_fifo

Receive-side elastic buffer in the axis_clk domain, directly downstream of the IO serdes RX path. It captures every beat the serdes presents on is_as_* (the serdes cannot be back-pressured) and replays the beats as an AXI-Stream master toward the axis switch. It generates the `as_is_tready` flow-control bit that the serdes TX path carries to the remote side, with enough headroom to absorb the link round-trip latency.

## Interface
- pDATA_WIDTH, 32, tdata width; tstrb/tkeep width is pDATA_WIDTH/8
- pDEPTH, 16, FIFO entries; power of two, ≥ 4
- pHEADROOM, 8, free-entry count at or below which `as_is_tready` drops; must be < pDEPTH
- pHYST, 2, extra free entries required before `as_is_tready` re-asserts; pHEADROOM+pHYST ≤ pDEPTH

Ports:
- axis_clk  in  1  only clock
- axis_rst_n  in  1  asynchronous, active-low reset
- is_as_tdata  in  pDATA_WIDTH  beat from serdes
- is_as_tstrb, is_as_tkeep  in  pDATA_WIDTH/8 each
- is_as_tlast  in  1
- is_as_tid, is_as_tuser  in  2 each
- is_as_tvalid  in  1  push strobe; no ready returned
- as_is_tready  out  1  local room indication, sent to the remote side
- m_axis_tdata/tstrb/tkeep/tlast/tid/tuser  out  same widths as inputs
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- fifo_level  out  $clog2(pDEPTH)+1  occupied entries
- overflow  out  1  sticky; set when a beat is dropped
- overflow_clr  in  1  synchronous clear of `overflow`

## Operation
- Entry = {tlast, tid, tuser, tkeep, tstrb, tdata}, 45 bits at default width.
- Push occurs when `is_as_tvalid`=1 and (level<pDEPTH or a pop occurs in the same cycle).
- A push attempt with level==pDEPTH and no pop drops the beat and sets `overflow`. The stored data is not corrupted.
- Pop occurs when `m_axis_tvalid` && `m_axis_tready`.
- Output is first-word-fall-through: `m_axis_tvalid` = (level≠0); `m_axis_*` present the head entry.
- Level: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers are $clog2(pDEPTH) bits and wrap naturally. Level is tracked separately, so full and empty are unambiguous.
- `as_is_tready` is registered through a two-state FSM:
  - OPEN (`as_is_tready`=1): go to HOLD when the next-cycle free count (pDEPTH − next_level) ≤ pHEADROOM.
  - HOLD (`as_is_tready`=0): go to OPEN when next-cycle free count ≥ pHEADROOM+pHYST.
- `overflow`: set on a drop, cleared by `overflow_clr`. When both occur in the same cycle, set wins.
- Beats with tvalid=0 are never stored. tdata content is not inspected.

## Timing
- Reset values:
  - `m_axis_tvalid`=0 and `m_axis_*` data outputs 0 (head of empty RAM is don't-care but forced 0).
  - `fifo_level`=0, `overflow`=0.
  - `as_is_tready`=0, FSM in HOLD.
- First clock after reset release: FSM moves to OPEN, `as_is_tready`=1.
- Push-to-`m_axis_tvalid` latency is 1 cycle (push at edge N, visible after edge N).
- Empty FIFO with simultaneous push: no pop is possible that cycle (tvalid=0); the beat appears the next cycle.
- Full FIFO with simultaneous push and pop: both occur, level stays pDEPTH, no overflow.
- `m_axis_*` are stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- Reset asserted mid-stream: contents are discarded and all outputs return to reset values asynchronously.

## Structure
- Package fsic_axis_rx_pkg holds the entry-width localparam (derived from pDATA_WIDTH) and pack/unpack functions for the entry.
- Sub-module fsic_sync_fifo_mem holds the storage: pDEPTH × entry-width register array, one write port, and an asynchronous read at the head pointer.
- The top level holds the pointers, level counter, flow-control FSM and overflow flag.

## Test plan
- Reset release, no traffic: `as_is_tready` 0→1 one cycle after release; `m_axis_tvalid`=0; `fifo_level`=0.
- Push 0x00000001..0x00000010 back-to-back with `m_axis_tready`=0: `as_is_tready` drops on the cycle level reaches 8 (free=8). Level ends at 16 and `overflow` stays 0.
- From full, push 0xDEADBEEF with `m_axis_tready`=0: beat dropped, `overflow`=1, level stays 16. Draining then yields 0x1..0x10 unchanged.
- From full, raise `m_axis_tready`=1 while pushing every cycle: level holds at 16, output order is intact, no overflow.
- Drain from level 16: `as_is_tready` re-asserts when level falls to 6 (free=10), not at free=9.
- Push with tlast=1, tid=2, tuser=1, tkeep=0xF; pulse `overflow_clr` on the same cycle as a drop: all sideband bits are reproduced at the output, and `overflow` remains 1.

Source files
------------

// File: rtl/fsic_axis_rx_pkg.sv
// Shared entry layout for the serdes RX elastic buffer.
// Entry = {tlast, tid, tuser, tkeep, tstrb, tdata}.
package fsic_axis_rx_pkg;

  localparam int DATA_W = 32;
  localparam int MAX_DW = 128;
  localparam int MAX_SW = MAX_DW / 8;
  localparam int MAX_EW = MAX_DW + 2 * MAX_SW + 5;

  function automatic int entry_w(input int dw);
    return dw + 2 * (dw / 8) + 5;
  endfunction

  localparam int ENTRY_W = entry_w(DATA_W);

  typedef struct packed {
    logic              last;
    logic [1:0]        id;
    logic [1:0]        user;
    logic [MAX_SW-1:0] keep;
    logic [MAX_SW-1:0] strb;
    logic [MAX_DW-1:0] data;
  } rx_beat_t;

  // Fields are packed LSB-first at offsets set by the live data width.
  function automatic logic [MAX_EW-1:0] entry_pack(
    input int                dw,
    input logic [MAX_DW-1:0] data,
    input logic [MAX_SW-1:0] strb,
    input logic [MAX_SW-1:0] keep,
    input logic [1:0]        user,
    input logic [1:0]        id,
    input logic              last
  );
    logic [MAX_EW-1:0] e;
    int sw;
    sw = dw / 8;
    e = MAX_EW'(data);
    e = e | (MAX_EW'(strb) << dw);
    e = e | (MAX_EW'(keep) << (dw + sw));
    e = e | (MAX_EW'(user) << (dw + 2 * sw));
    e = e | (MAX_EW'(id) << (dw + 2 * sw + 2));
    e = e | (MAX_EW'(last) << (dw + 2 * sw + 4));
    return e;
  endfunction

  function automatic rx_beat_t entry_unpack(
    input int                dw,
    input logic [MAX_EW-1:0] e
  );
    rx_beat_t b;
    int sw;
    logic [MAX_DW-1:0] dmask;
    logic [MAX_SW-1:0] smask;
    sw = dw / 8;
    dmask = (MAX_DW'(1) << dw) - MAX_DW'(1);
    smask = (MAX_SW'(1) << sw) - MAX_SW'(1);
    b.data = MAX_DW'(e) & dmask;
    b.strb = MAX_SW'(e >> dw) & smask;
    b.keep = MAX_SW'(e >> (dw + sw)) & smask;
    b.user = 2'(e >> (dw + 2 * sw));
    b.id   = 2'(e >> (dw + 2 * sw + 2));
    b.last = 1'(e >> (dw + 2 * sw + 4));
    return b;
  endfunction

endpackage

// File: rtl/fsic_sync_fifo_mem.sv
// Register-array storage for the RX FIFO.
// One write port, combinational read at the head pointer.
module fsic_sync_fifo_mem #(
  parameter int pDEPTH = 16,
  parameter int pWIDTH = 45
) (
  input  logic                      axis_clk,
  input  logic                      we,
  input  logic [$clog2(pDEPTH)-1:0] waddr,
  input  logic [pWIDTH-1:0]         wdata,
  input  logic [$clog2(pDEPTH)-1:0] raddr,
  output logic [pWIDTH-1:0]         rdata
);

  logic [pWIDTH-1:0] mem [pDEPTH];

  always_ff @(posedge axis_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsic_axis_rx_fifo.sv
// Serdes RX elastic buffer: absorbs unthrottled beats, replays
// them as AXI-Stream, and drives remote flow control.
module fsic_axis_rx_fifo
  import fsic_axis_rx_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16,
  parameter int pHEADROOM   = 8,
  parameter int pHYST       = 2
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst_n,
  input  logic [pDATA_WIDTH-1:0]     is_as_tdata,
  input  logic [pDATA_WIDTH/8-1:0]   is_as_tstrb,
  input  logic [pDATA_WIDTH/8-1:0]   is_as_tkeep,
  input  logic                       is_as_tlast,
  input  logic [1:0]                 is_as_tid,
  input  logic [1:0]                 is_as_tuser,
  input  logic                       is_as_tvalid,
  output logic                       as_is_tready,
  output logic [pDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [pDATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [pDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [1:0]                 m_axis_tid,
  output logic [1:0]                 m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(pDEPTH):0]    fifo_level,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;
  localparam int EW = entry_w(pDATA_WIDTH);
  localparam int SW = pDATA_WIDTH / 8;
  localparam logic [LW-1:0] FULL  = LW'(pDEPTH);
  localparam logic [LW-1:0] LO_TH = LW'(pHEADROOM);
  localparam logic [LW-1:0] HI_TH = LW'(pHEADROOM + pHYST);

  typedef enum logic {HOLD = 1'b0, OPEN = 1'b1} fc_state_t;

  fc_state_t       state_q, state_d;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q, level_d, free_d;
  logic            ovf_q;
  logic            push, pop, drop;
  logic [EW-1:0]   wentry, rentry;
  rx_beat_t        head;

  assign pop  = m_axis_tvalid & m_axis_tready;
  assign push = is_as_tvalid & ((level_q != FULL) | pop);
  assign drop = is_as_tvalid & (level_q == FULL) & ~pop;

  assign wentry = EW'(entry_pack(pDATA_WIDTH,
                                 MAX_DW'(is_as_tdata),
                                 MAX_SW'(is_as_tstrb),
                                 MAX_SW'(is_as_tkeep),
                                 is_as_tuser,
                                 is_as_tid,
                                 is_as_tlast));

  fsic_sync_fifo_mem #(
    .pDEPTH (pDEPTH),
    .pWIDTH (EW)
  ) u_mem (
    .axis_clk (axis_clk),
    .we       (push),
    .waddr    (wptr_q),
    .wdata    (wentry),
    .raddr    (rptr_q),
    .rdata    (rentry)
  );

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    free_d = FULL - level_d;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      // A drop in the same cycle as a clear must stay visible.
      if (drop)              ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state_q <= HOLD;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OPEN:    if (free_d <= LO_TH) state_d = HOLD;
      HOLD:    if (free_d >= HI_TH) state_d = OPEN;
      default: state_d = HOLD;
    endcase
  end

  assign as_is_tready = (state_q == OPEN);
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;
  assign m_axis_tvalid = (level_q != '0);

  // Head of an empty RAM is stale, so the outputs are forced low.
  always_comb begin
    head = entry_unpack(pDATA_WIDTH, MAX_EW'(rentry));
    m_axis_tdata = '0;
    m_axis_tstrb = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    m_axis_tid   = '0;
    m_axis_tuser = '0;
    if (m_axis_tvalid) begin
      m_axis_tdata = pDATA_WIDTH'(head.data);
      m_axis_tstrb = SW'(head.strb);
      m_axis_tkeep = SW'(head.keep);
      m_axis_tlast = head.last;
      m_axis_tid   = head.id;
      m_axis_tuser = head.user;
    end
  end

endmodule

// File: tb/tb_fsic_axis_rx_fifo.sv
// Scoreboard bench for fsic_axis_rx_fifo.
// Stimulus queues expected beats; a monitor checks each pop.
module tb_fsic_axis_rx_fifo;

  logic        axis_clk;
  logic        axis_rst_n;
  logic [31:0] is_as_tdata;
  logic [3:0]  is_as_tstrb, is_as_tkeep;
  logic        is_as_tlast;
  logic [1:0]  is_as_tid, is_as_tuser;
  logic        is_as_tvalid;
  logic        as_is_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb, m_axis_tkeep;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tid, m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        overflow_clr;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  k;
    logic        l;
    logic [1:0]  id;
    logic [1:0]  u;
  } beat_t;

  beat_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  fsic_axis_rx_fifo dut (
    .axis_clk      (axis_clk),
    .axis_rst_n    (axis_rst_n),
    .is_as_tdata   (is_as_tdata),
    .is_as_tstrb   (is_as_tstrb),
    .is_as_tkeep   (is_as_tkeep),
    .is_as_tlast   (is_as_tlast),
    .is_as_tid     (is_as_tid),
    .is_as_tuser   (is_as_tuser),
    .is_as_tvalid  (is_as_tvalid),
    .as_is_tready  (as_is_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge axis_clk) begin
    if (axis_rst_n && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0h expected none",
                 m_axis_tdata);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("pop_data", 64'(m_axis_tdata), 64'(e.d));
        chk("pop_side",
            64'({m_axis_tlast, m_axis_tid, m_axis_tuser,
                 m_axis_tkeep, m_axis_tstrb}),
            64'({e.l, e.id, e.u, e.k, e.s}));
      end
    end
  end

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic drive(input beat_t b, input bit store);
    is_as_tvalid = 1'b1;
    is_as_tdata  = b.d;
    is_as_tstrb  = b.s;
    is_as_tkeep  = b.k;
    is_as_tlast  = b.l;
    is_as_tid    = b.id;
    is_as_tuser  = b.u;
    if (store) sb.push_back(b);
  endtask

  task automatic idle();
    is_as_tvalid = 1'b0;
    is_as_tdata  = '0;
    is_as_tstrb  = '0;
    is_as_tkeep  = '0;
    is_as_tlast  = 1'b0;
    is_as_tid    = '0;
    is_as_tuser  = '0;
  endtask

  function automatic beat_t plain(input logic [31:0] d);
    beat_t b;
    b.d = d; b.s = 4'hF; b.k = 4'hF;
    b.l = 1'b0; b.id = 2'd0; b.u = 2'd0;
    return b;
  endfunction

  task automatic drain(input string name);
    int budget;
    m_axis_tready = 1'b1;
    budget = 40;
    while (fifo_level != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk({name, "_timeout"}, 64'(budget == 0), 64'd0);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    m_axis_tready = 1'b0;
  endtask

  initial begin
    beat_t b;
    axis_rst_n    = 1'b0;
    m_axis_tready = 1'b0;
    overflow_clr  = 1'b0;
    idle();
    step();
    step();
    chk("rst_tready", 64'(as_is_tready), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    axis_rst_n = 1'b1;
    #1;
    chk("rel_tready_0", 64'(as_is_tready), 64'd0);
    step();
    chk("rel_tready_1", 64'(as_is_tready), 64'd1);
    chk("rel_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Fill to full with no drain; tready drops as level hits 8.
    for (int i = 1; i <= 16; i++) begin
      drive(plain(32'(i)), 1'b1);
      step();
      chk("fill_level", 64'(fifo_level), 64'(i));
      chk("fill_tready", 64'(as_is_tready), 64'(i < 8));
    end
    idle();
    chk("fill_ovf", 64'(overflow), 64'd0);
    chk("fill_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("fill_head", 64'(m_axis_tdata), 64'h1);

    drive(plain(32'hDEADBEEF), 1'b0);
    step();
    idle();
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_level", 64'(fifo_level), 64'd16);
    chk("drop_head", 64'(m_axis_tdata), 64'h1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);

    // Full with push and pop together.
    m_axis_tready = 1'b1;
    for (int i = 17; i <= 24; i++) begin
      drive(plain(32'(i)), 1'b1);
      step();
      chk("fp_level", 64'(fifo_level), 64'd16);
      chk("fp_ovf", 64'(overflow), 64'd0);
    end
    idle();

    // Drain 16 entries; tready returns at level 6.
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("dr_level", 64'(fifo_level), 64'(16 - k));
      chk("dr_tready", 64'(as_is_tready), 64'((16 - k) <= 6));
    end
    m_axis_tready = 1'b0;
    chk("dr_sb_empty", 64'(sb.size()), 64'd0);
    chk("dr_tvalid", 64'(m_axis_tvalid), 64'd0);

    // Sideband fill, then drop with a simultaneous clear.
    for (int i = 0; i < 16; i++) begin
      b.d  = 32'hA500_0000 + 32'(i);
      b.s  = 4'(i);
      b.k  = (i == 0) ? 4'hF : 4'(15 - i);
      b.l  = (i == 0) ? 1'b1 : 1'(i);
      b.id = (i == 0) ? 2'd2 : 2'(i >> 1);
      b.u  = (i == 0) ? 2'd1 : 2'(i >> 2);
      drive(b, 1'b1);
      step();
    end
    drive(plain(32'h0BAD_0BAD), 1'b0);
    overflow_clr = 1'b1;
    step();
    idle();
    overflow_clr = 1'b0;
    chk("setwins_ovf", 64'(overflow), 64'd1);
    chk("sb_head_side",
        64'({m_axis_tlast, m_axis_tid, m_axis_tuser, m_axis_tkeep}),
        64'({1'b1, 2'd2, 2'd1, 4'hF}));
    drain("sb_drain");

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      drive(plain(32'hC0 + 32'(i)), 1'b0);
      step();
    end
    idle();
    #2;
    axis_rst_n = 1'b0;
    #1;
    chk("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mrst_level", 64'(fifo_level), 64'd0);
    chk("mrst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("mrst_tready", 64'(as_is_tready), 64'd0);
    chk("mrst_ovf", 64'(overflow), 64'd0);
    step();
    axis_rst_n = 1'b1;
    step();
    chk("mrst_reopen", 64'(as_is_tready), 64'd1);
    drive(plain(32'h1234_5678), 1'b1);
    step();
    idle();
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
